// File: rtl/player.sv
// player: replays a host-loaded dual-clock sample memory onto w_out, one word
// per w_clk cycle, with one-shot or looped playback, a programmable pass
// length and a pause gate.
module player #(
  parameter int width    = 8,
  parameter int timeBits = 10
) (
  input  logic                w_clk,
  input  logic                w_reset_n,
  input  logic                clk,
  input  logic                w_loop,
  input  logic [timeBits:0]   w_length,
  input  logic                w_enable,
  output logic [width-1:0]    w_out,
  output logic                w_valid,
  output logic                w_done,
  input  logic                h_write,
  input  logic                h_read,
  input  logic [timeBits-1:0] h_addr,
  input  logic [width-1:0]    h_writedata,
  output logic [width-1:0]    h_readdata
);

  localparam int unsigned DEPTH = 2 ** timeBits;
  localparam logic [timeBits:0] DEPTH_L = {1'b1, {timeBits{1'b0}}};

  typedef enum logic {PLAY, DONE} state_t;

  logic [width-1:0] mem [DEPTH];

  // Power-up values: idle in DONE with full-depth, one-shot settings.
  state_t            state_q     = DONE;
  state_t            state_d;
  logic [timeBits:0] p_q         = '0;
  logic [timeBits:0] p_d;
  logic [timeBits:0] len_q       = DEPTH_L;
  logic [timeBits:0] len_d;
  logic              loop_q      = 1'b0;
  logic              loop_d;
  logic              valid_q     = 1'b0;
  logic              valid_d;
  logic              done_q      = 1'b1;
  logic              done_d;
  logic [width-1:0]  w_out_q     = '0;
  logic [width-1:0]  h_readdata_q = '0;
  logic              sample_en;

  // Host port: write has priority; a read registers the addressed word.
  always_ff @(posedge clk) begin
    if (h_write) begin
      mem[h_addr] <= h_writedata;
    end else if (h_read) begin
      h_readdata_q <= mem[h_addr];
    end
  end

  // Playback next-state: reset arms and latches settings, PLAY steps the pointer.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    len_d     = len_q;
    loop_d    = loop_q;
    valid_d   = 1'b0;
    done_d    = done_q;
    sample_en = 1'b0;
    if (!w_reset_n) begin
      state_d = PLAY;
      p_d     = '0;
      done_d  = 1'b0;
      loop_d  = w_loop;
      len_d   = (w_length == '0 || w_length > DEPTH_L) ? DEPTH_L : w_length;
    end else begin
      case (state_q)
        PLAY: begin
          if (w_enable) begin
            sample_en = 1'b1;
            valid_d   = 1'b1;
            if (p_q == len_q - 1'b1) begin
              if (loop_q) begin
                p_d = '0;
              end else begin
                // Park the pointer one past the end so the pass reads as complete.
                p_d     = len_q;
                state_d = DONE;
              end
            end else begin
              p_d = p_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_d = 1'b1;
        end
      endcase
    end
  end

  // Playback state and control registers.
  always_ff @(posedge w_clk) begin
    state_q <= state_d;
    p_q     <= p_d;
    len_q   <= len_d;
    loop_q  <= loop_d;
    valid_q <= valid_d;
    done_q  <= done_d;
  end

  // Play-port memory read; w_out holds whenever no sample is presented.
  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      w_out_q <= '0;
    end else if (sample_en) begin
      w_out_q <= mem[p_q[timeBits-1:0]];
    end
  end

  assign w_out      = w_out_q;
  assign w_valid    = valid_q;
  assign w_done     = done_q;
  assign h_readdata = h_readdata_q;

endmodule

// File: tb/tb_player.sv
// tb_player: directed, table-driven checks of player playback and host port.
module tb_player;

  localparam int W  = 8;
  localparam int TB = 4;

  logic          w_clk = 1'b0;
  logic          clk = 1'b0;
  logic          w_reset_n = 1'b1;
  logic          w_loop = 1'b0;
  logic [TB:0]   w_length = '0;
  logic          w_enable = 1'b0;
  logic [W-1:0]  w_out;
  logic          w_valid;
  logic          w_done;
  logic          h_write = 1'b0;
  logic          h_read = 1'b0;
  logic [TB-1:0] h_addr = '0;
  logic [W-1:0]  h_writedata = '0;
  logic [W-1:0]  h_readdata;

  int checks = 0;
  int failures = 0;

  player #(.width(W), .timeBits(TB)) dut (
    .w_clk(w_clk), .w_reset_n(w_reset_n), .clk(clk),
    .w_loop(w_loop), .w_length(w_length), .w_enable(w_enable),
    .w_out(w_out), .w_valid(w_valid), .w_done(w_done),
    .h_write(h_write), .h_read(h_read), .h_addr(h_addr),
    .h_writedata(h_writedata), .h_readdata(h_readdata)
  );

  always #5 w_clk = ~w_clk;
  always #7 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [W-1:0] out;
    logic         valid;
    logic         done;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [W-1:0] o,
                     input logic v, input logic d);
    vec_t x;
    x.rst_n = r; x.en = e; x.out = o; x.valid = v; x.done = d;
    vt.push_back(x);
  endtask

  task automatic wtick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic hwrite(input logic [TB-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    h_write = 1'b1; h_addr = a; h_writedata = d;
    @(posedge clk); #1;
    h_write = 1'b0;
  endtask

  task automatic hread(input logic [TB-1:0] a);
    @(posedge clk); #1;
    h_read = 1'b1; h_addr = a;
    @(posedge clk); #1;
    h_read = 1'b0;
  endtask

  task automatic step_chk(input string name, input logic [W-1:0] o,
                          input logic v, input logic d);
    wtick();
    chk({name, ".out"}, int'(w_out), int'(o));
    chk({name, ".valid"}, int'(w_valid), int'(v));
    chk({name, ".done"}, int'(w_done), int'(d));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up state, before any w_clk edge.
    #1;
    chk("pwr.out", int'(w_out), 0);
    chk("pwr.valid", int'(w_valid), 0);
    chk("pwr.done", int'(w_done), 1);

    // Load mem[i] = 0x10 + i while playback is held in reset.
    w_reset_n = 1'b0;
    for (int i = 0; i < 8; i++) hwrite(4'(i), 8'(8'h10 + i));

    // One-shot, then pause and mid-run reset.
    w_length = 5'd8; w_loop = 1'b0;
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) add(1'b1, 1'b1, 8'(8'h10 + k), 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h17, 1'b0, 1'b1);
    add(1'b1, 1'b1, 8'h17, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b1, 1'b1, 8'(8'h10 + k), 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h13, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h13, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h14, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
    foreach (vt[i]) begin
      w_reset_n = vt[i].rst_n;
      w_enable  = vt[i].en;
      step_chk($sformatf("vec%0d", i), vt[i].out, vt[i].valid, vt[i].done);
    end

    // Looped playback of three samples, settings changed after release are ignored.
    w_length = 5'd3; w_loop = 1'b1; w_enable = 1'b1;
    w_reset_n = 1'b0;
    step_chk("loop.rst", 8'h00, 1'b0, 1'b0);
    w_reset_n = 1'b1;
    w_loop = 1'b0; w_length = 5'd1;
    for (int k = 0; k < 24; k++)
      step_chk($sformatf("loop%0d", k), 8'(8'h10 + (k % 3)), 1'b1, 1'b0);

    // Full-depth via w_length=0 and w_length=17, with mem[i] = i.
    w_reset_n = 1'b0;
    for (int i = 0; i < 16; i++) hwrite(4'(i), 8'(i));
    for (int pass = 0; pass < 2; pass++) begin
      w_loop = 1'b0;
      w_length = (pass == 0) ? 5'd0 : 5'd17;
      w_reset_n = 1'b0;
      step_chk($sformatf("full%0d.rst", pass), 8'h00, 1'b0, 1'b0);
      w_reset_n = 1'b1;
      w_length = 5'd2;
      for (int k = 0; k < 16; k++)
        step_chk($sformatf("full%0d.s%0d", pass, k), 8'(k), 1'b1, 1'b0);
      step_chk($sformatf("full%0d.end", pass), 8'h0F, 1'b0, 1'b1);
    end

    // Host port: write/read, then simultaneous write+read leaves readdata alone.
    hwrite(4'd5, 8'hA5);
    hread(4'd5);
    chk("host.rd", int'(h_readdata), 8'hA5);
    @(posedge clk); #1;
    h_write = 1'b1; h_read = 1'b1; h_addr = 4'd5; h_writedata = 8'h3C;
    @(posedge clk); #1;
    h_write = 1'b0; h_read = 1'b0;
    chk("host.wr_rd", int'(h_readdata), 8'hA5);
    hread(4'd5);
    chk("host.rd2", int'(h_readdata), 8'h3C);
    hread(4'd6);
    chk("host.rd3", int'(h_readdata), 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player.md
Name: player

Overview:
- Playback counterpart of the sampler. A host on `clk` fills a dual-clock sample memory, then the block replays it one word per `w_clk` cycle onto `w_out`.
- Supports one-shot or looped playback, programmable length and a pause gate.
- Sits between the Avalon-side control logic and the stimulus pins of the device under test.

Parameters:
- width, 8, bits per sample word.
- timeBits, 10, log2 of memory depth; depth D = 2**timeBits.

Ports:
- w_clk  in  1  playback clock.
- w_reset_n  in  1  playback reset; synchronous, active-low, on w_clk. Also arms playback.
- clk  in  1  host clock, asynchronous to w_clk.
- w_loop  in  1  loop mode; latched while w_reset_n=0.
- w_length  in  timeBits+1  samples per pass; latched while w_reset_n=0.
- w_enable  in  1  playback gate; low = pause.
- w_out  out  width  current sample.
- w_valid  out  1  w_out holds a sample presented this cycle.
- w_done  out  1  one-shot pass complete, or idle.
- h_write  in  1  host write strobe.
- h_read  in  1  host read strobe.
- h_addr  in  timeBits  host word address.
- h_writedata  in  width  host write data.
- h_readdata  out  width  host read data.

Behaviour:
- Memory is D x width, true dual-clock: the host port on clk, the play port on w_clk. No other cross-domain logic.
- Host port:
  - h_write stores h_writedata at h_addr on the clk edge.
  - h_read registers mem[h_addr] into h_readdata; data is valid after 1 clk edge; h_readdata holds otherwise.
  - h_write takes priority over h_read in the same cycle; the read is then ignored.
  - Host access same-address concurrent with playback gives undefined data; different addresses are legal.
- Length rule: len_q = w_length if 1 <= w_length <= D, otherwise D (0 means full depth).
- Playback state machine on w_clk, states PLAY and DONE, power-up state DONE:
  - Power-up values: w_out=0, w_valid=0, w_done=1, pointer p=0, len_q=D, loop_q=0.
  - w_reset_n=0 (any state, overrides all): state<=PLAY, p<=0, w_out<=0, w_valid<=0, w_done<=0, len_q and loop_q latched from inputs.
  - PLAY, w_enable=1: w_out<=mem[p], w_valid<=1.
    - If p=len_q-1 and loop_q=1, then p<=0.
    - If p=len_q-1 and loop_q=0, then p<=len_q and state<=DONE.
    - Otherwise p<=p+1.
  - PLAY, w_enable=0: p and w_out hold, w_valid<=0. No sample is skipped on resume.
  - DONE: w_valid<=0, w_done<=1, w_out holds the last sample, p holds.
- Latency:
  - First sample appears on the first w_clk edge with w_reset_n=1 and w_enable=1.
  - w_done rises (and w_valid falls) on the edge after the last sample is presented.
- Looped mode never asserts w_done; the wrap is seamless (mem[len_q-1] is directly followed by mem[0]).
- w_loop and w_length changes while w_reset_n=1 have no effect.
- Reset mid-playback aborts immediately per the reset rule; playback restarts from mem[0] after release.
- Pointer p is timeBits+1 bits wide; arithmetic never wraps outside the rule above.

Test Plan:
- One-shot: host writes mem[i]=0x10+i for i=0..7; w_length=8, w_loop=0, w_enable=1; pulse reset.
  -> w_out = 0x10..0x17 on edges 1..8 after release, w_valid=1 for exactly 8 cycles.
  -> w_done=1 from edge 9, w_out stays 0x17.
- Loop: same memory, w_length=3, w_loop=1 -> w_out cycles 0x10,0x11,0x12,0x10,... with w_valid continuously 1; w_done=0 for 20+ cycles.
- Length 0 with timeBits=4, mem[i]=i -> 16 samples 0x00..0x0F, then w_done=1. Also w_length=17 -> same 16 samples.
- Pause: drop w_enable for 2 cycles after sample 0x13 -> w_out holds 0x13, w_valid=0 for 2 cycles, next valid sample is 0x14.
- Reset mid-run: assert w_reset_n=0 after sample 0x14 -> next edge gives w_out=0, w_valid=0, w_done=0; release -> 0x10 on the first edge.
- Host port: write h_addr=5 data 0xA5, then read h_addr=5 -> h_readdata=0xA5 one clk later. Simultaneous h_write/h_read -> write occurs, h_readdata unchanged.
